// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, redirect handling and ID back-pressure.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched / perf_redirects counters.
module fetch_stage #(
  parameter int                DWIDTH    = 32,
  parameter logic [DWIDTH-1:0] RESET_PC  = '0,
  parameter logic [DWIDTH-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic [DWIDTH-1:0] if_pc,
  output logic [DWIDTH-1:0] if_instr,
  output logic              if_valid,
  input  logic [DWIDTH-1:0] if_npc,
  input  logic              stall,
  input  logic              control_hazard,
  input  logic [DWIDTH-1:0] ex_jpc,
  output logic [DWIDTH-1:0] id_pc,
  output logic [DWIDTH-1:0] id_instr,
  output logic              id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_redirects
`endif
);

  // Memory handshake: a request is live while imem_req=1 and completes in the
  // cycle imem_ready=1 (possibly the first one); imem_addr must not move meanwhile.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] pc, pc_nxt;
  logic [DWIDTH-1:0] redir, redir_nxt;
  logic [DWIDTH-1:0] instr_buf, instr_buf_nxt;
  logic [DWIDTH-1:0] id_pc_nxt, id_instr_nxt;
  logic              id_valid_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      redir     <= RESET_PC;
      instr_buf <= NOP_INSTR;
      id_pc     <= '0;
      id_instr  <= NOP_INSTR;
      id_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      redir     <= redir_nxt;
      instr_buf <= instr_buf_nxt;
      id_pc     <= id_pc_nxt;
      id_instr  <= id_instr_nxt;
      id_valid  <= id_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    redir_nxt     = redir;
    instr_buf_nxt = instr_buf;
    id_pc_nxt     = id_pc;
    id_instr_nxt  = id_instr;
    id_valid_nxt  = id_valid;
    if (control_hazard) begin
      id_valid_nxt = 1'b0;
      id_instr_nxt = NOP_INSTR;
      // A request still in flight must finish at its own address, so park the target.
      if (state != S_HOLD && !imem_ready) begin
        redir_nxt = ex_jpc;
        state_nxt = S_DRAIN;
      end else begin
        pc_nxt    = ex_jpc;
        state_nxt = S_FETCH;
      end
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_ready && !stall) begin
            id_pc_nxt    = pc;
            id_instr_nxt = imem_rdata;
            id_valid_nxt = 1'b1;
            pc_nxt       = if_npc;
          end else if (imem_ready) begin
            instr_buf_nxt = imem_rdata;
            state_nxt     = S_HOLD;
          end else if (!stall) begin
            id_valid_nxt = 1'b0;
            id_instr_nxt = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            id_pc_nxt    = pc;
            id_instr_nxt = instr_buf;
            id_valid_nxt = 1'b1;
            pc_nxt       = if_npc;
            state_nxt    = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            id_valid_nxt = 1'b0;
            id_instr_nxt = NOP_INSTR;
          end
          if (imem_ready) begin
            pc_nxt    = redir;
            state_nxt = S_FETCH;
          end
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if_pc     = pc;
    if_instr  = NOP_INSTR;
    if_valid  = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = rst;
        if (rst && imem_ready) begin
          if_valid = 1'b1;
          if_instr = imem_rdata;
        end
      end
      S_HOLD: begin
        if_valid = 1'b1;
        if_instr = instr_buf;
      end
      S_DRAIN: imem_req = rst;
      default: imem_req = 1'b0;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  // A stalled slot is not a new transfer, and a hazard always clears id_valid_nxt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (id_valid_nxt && !stall) perf_fetched <= perf_fetched + 32'd1;
      if (control_hazard) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the main scenarios, then randomized
// memory latency / stall / redirect traffic checked against a stream-level model.
module tb_fetch_stage;
  localparam int           W   = 32;
  localparam logic [W-1:0] NOP = 32'h0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         imem_req, imem_ready, if_valid, stall, control_hazard, id_valid;
  logic [W-1:0] imem_addr, imem_rdata, if_pc, if_instr, if_npc, ex_jpc, id_pc, id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  perf_fetched, perf_redirects;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .if_npc(if_npc),
    .stall(stall), .control_hazard(control_hazard), .ex_jpc(ex_jpc),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
  );

  // Instruction memory contents and branch predictor, both pure functions of the address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [W-1:0] pred(input logic [W-1:0] pc);
    return (pc[7:0] == 8'hAC) ? pc + 32'h200 : pc + 32'd4;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign if_npc     = pred(if_pc);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic hz, input logic [W-1:0] jpc, input logic rdy);
    @(negedge clk);
    stall = st; control_hazard = hz; ex_jpc = jpc; imem_ready = rdy;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_next, prev_addr, snap_pc, snap_instr, jpc;
    logic         st, hz, rdy, st_prev, hz_prev, req_pending, snap_valid;
    int           waits_left, idle, max_gap, n_deliv;
    logic [31:0]  exp_fetched, exp_redir;

    stall = 1'b0; control_hazard = 1'b0; ex_jpc = '0; imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_redirects", perf_redirects, 32'h0);
`endif
    rst = 1'b1;

    // Zero-wait memory: one word per cycle.
    cyc(0, 0, 0, 1);
    chk1("a0_req", imem_req, 1'b1); chk("a0_addr", imem_addr, 32'h0);
    chk1("a0_if_valid", if_valid, 1'b1); chk("a0_if_instr", if_instr, mem_word(32'h0));
    chk1("a0_id_valid", id_valid, 1'b0);
    cyc(0, 0, 0, 1);
    chk("a1_addr", imem_addr, 32'h4); chk1("a1_id_valid", id_valid, 1'b1);
    chk("a1_id_pc", id_pc, 32'h0); chk("a1_id_instr", id_instr, mem_word(32'h0));
    cyc(0, 0, 0, 1);
    chk("a2_addr", imem_addr, 32'h8); chk("a2_id_pc", id_pc, 32'h4);
    cyc(0, 0, 0, 1);
    chk("a3_addr", imem_addr, 32'hC); chk("a3_id_pc", id_pc, 32'h8);

    // Two wait cycles at 0x10.
    cyc(0, 0, 0, 0);
    chk("b0_addr", imem_addr, 32'h10); chk1("b0_if_valid", if_valid, 1'b0); chk("b0_id_pc", id_pc, 32'hC);
    cyc(0, 0, 0, 0);
    chk1("b1_req", imem_req, 1'b1); chk("b1_addr", imem_addr, 32'h10);
    chk1("b1_id_valid", id_valid, 1'b0); chk("b1_id_instr", id_instr, NOP);
    cyc(0, 0, 0, 1);
    chk("b2_addr", imem_addr, 32'h10); chk1("b2_if_valid", if_valid, 1'b1);
    chk("b2_if_instr", if_instr, mem_word(32'h10));
    cyc(0, 0, 0, 1);
    chk("b3_addr", imem_addr, 32'h14); chk("b3_id_pc", id_pc, 32'h10); chk1("b3_id_valid", id_valid, 1'b1);

    // Stall while the word at 0x18 arrives.
    cyc(1, 0, 0, 1);
    chk("c0_addr", imem_addr, 32'h18); chk1("c0_if_valid", if_valid, 1'b1); chk("c0_id_pc", id_pc, 32'h14);
    cyc(1, 0, 0, 0);
    chk1("c1_req", imem_req, 1'b0); chk1("c1_if_valid", if_valid, 1'b1);
    chk("c1_if_instr", if_instr, mem_word(32'h18)); chk("c1_id_pc", id_pc, 32'h14);
    chk1("c1_id_valid", id_valid, 1'b1);
    cyc(1, 0, 0, 0);
    chk1("c2_req", imem_req, 1'b0); chk("c2_id_pc", id_pc, 32'h14);
    cyc(0, 0, 0, 0);
    chk1("c3_req", imem_req, 1'b0); chk("c3_id_pc", id_pc, 32'h14);
    cyc(0, 0, 0, 1);
    chk1("c4_req", imem_req, 1'b1); chk("c4_addr", imem_addr, 32'h1C);
    chk("c4_id_pc", id_pc, 32'h18); chk("c4_id_instr", id_instr, mem_word(32'h18));

    // Redirect to 0x40 during a waited fetch at 0x20.
    cyc(0, 0, 0, 0);
    chk("d0_addr", imem_addr, 32'h20); chk("d0_id_pc", id_pc, 32'h1C);
    cyc(0, 1, 32'h40, 0);
    chk("d1_addr", imem_addr, 32'h20); chk1("d1_id_valid", id_valid, 1'b0);
    cyc(0, 0, 0, 0);
    chk1("d2_req", imem_req, 1'b1); chk("d2_addr", imem_addr, 32'h20); chk1("d2_if_valid", if_valid, 1'b0);
    cyc(0, 0, 0, 1);
    chk("d3_addr", imem_addr, 32'h20); chk1("d3_if_valid", if_valid, 1'b0);
    cyc(0, 0, 0, 1);
    chk("d4_addr", imem_addr, 32'h40); chk1("d4_id_valid", id_valid, 1'b0);
    cyc(0, 0, 0, 1);
    chk("d5_addr", imem_addr, 32'h44); chk("d5_id_pc", id_pc, 32'h40); chk1("d5_id_valid", id_valid, 1'b1);

    // Redirect together with stall.
    cyc(1, 1, 32'h80, 1);
    chk("e0_addr", imem_addr, 32'h48); chk("e0_id_pc", id_pc, 32'h44);
    cyc(1, 0, 0, 1);
    chk1("e1_id_valid", id_valid, 1'b0); chk("e1_id_instr", id_instr, NOP);
    chk("e1_if_pc", if_pc, 32'h80); chk("e1_addr", imem_addr, 32'h80);
    cyc(0, 0, 0, 0);
    chk1("e2_req", imem_req, 1'b0);
    cyc(0, 0, 0, 0);
    chk("e3_id_pc", id_pc, 32'h80); chk1("e3_id_valid", id_valid, 1'b1);
    chk1("e3_req", imem_req, 1'b1); chk("e3_addr", imem_addr, 32'h84);

    // Reset pulse in the middle of an outstanding request.
    #2 rst = 1'b0;
    #1;
    chk1("f_req", imem_req, 1'b0); chk1("f_id_valid", id_valid, 1'b0); chk("f_if_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("f_perf_fetched", perf_fetched, 32'h0);
    chk("f_perf_redirects", perf_redirects, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Restart at RESET_PC, then a redirect that wraps the PC through 2^32.
    cyc(0, 0, 0, 1);
    chk1("g0_req", imem_req, 1'b1); chk("g0_addr", imem_addr, 32'h0); chk1("g0_id_valid", id_valid, 1'b0);
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    chk("g1_addr", imem_addr, 32'h4); chk("g1_id_pc", id_pc, 32'h0);
    cyc(0, 0, 0, 1);
    chk("g2_addr", imem_addr, 32'hFFFF_FFFC); chk1("g2_id_valid", id_valid, 1'b0);
    cyc(0, 0, 0, 1);
    chk("g3_addr", imem_addr, 32'h0); chk("g3_id_pc", id_pc, 32'hFFFF_FFFC);

    // Randomized traffic against the delivered-stream model.
    exp_next = 32'h0; exp_fetched = 32'd2; exp_redir = 32'd1;
    st_prev = 1'b0; hz_prev = 1'b0; req_pending = 1'b0; prev_addr = imem_addr;
    snap_pc = id_pc; snap_instr = id_instr; snap_valid = id_valid;
    waits_left = 0; idle = 0; max_gap = 0; n_deliv = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      st  = ($urandom_range(0, 3) == 0);
      hz  = ($urandom_range(0, 19) == 0);
      jpc = W'($urandom_range(0, 255)) << 2;
      if (i == 799) begin st = 1'b1; hz = 1'b0; end
      rdy = 1'b0;
      if (imem_req) begin
        if (waits_left == 0) begin
          rdy = 1'b1;
          waits_left = $urandom_range(0, 2);
        end else begin
          waits_left--;
        end
      end
      stall = st; control_hazard = hz; ex_jpc = jpc; imem_ready = rdy;
      #1;
      if (req_pending) begin
        chk1("r_req_held", imem_req, 1'b1);
        chk("r_addr_stable", imem_addr, prev_addr);
      end
      if (if_valid) chk("r_if_instr", if_instr, mem_word(if_pc));
      idle++;
      if (hz_prev) begin
        chk1("r_flush_valid", id_valid, 1'b0);
        chk("r_flush_instr", id_instr, NOP);
      end else if (st_prev) begin
        chk1("r_stall_valid", id_valid, snap_valid);
        chk("r_stall_pc", id_pc, snap_pc);
        chk("r_stall_instr", id_instr, snap_instr);
      end else if (id_valid) begin
        chk("r_deliver_pc", id_pc, exp_next);
        chk("r_deliver_instr", id_instr, mem_word(exp_next));
        exp_next = pred(exp_next);
        exp_fetched++;
        n_deliv++;
        idle = 0;
      end else begin
        chk("r_bubble_instr", id_instr, NOP);
      end
      if (idle > max_gap) max_gap = idle;
      if (hz) begin
        exp_next = jpc;
        exp_redir++;
      end
      st_prev = st; hz_prev = hz;
      snap_pc = id_pc; snap_instr = id_instr; snap_valid = id_valid;
      req_pending = imem_req && !imem_ready;
      prev_addr = imem_addr;
    end
    @(negedge clk);
    #1;
    chk1("r_gap_bounded", max_gap > 60, 1'b0);
    chk1("r_enough_delivered", n_deliv < 100, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("r_perf_fetched", perf_fetched, exp_fetched);
    chk("r_perf_redirects", perf_redirects, exp_redir);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
